// File: rtl/uart_img_loader_if.sv
// UART byte / image buffer / CNN result / UART tx bundle for uart_img_loader.
// master = loader side, slave = UART, buffer and CNN side.
interface uart_img_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              clr_rx_rdy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              img_rdy;
  logic              res_vld;
  logic [3:0]        res_digit;
  logic              trmt;
  logic [7:0]        tx_data;
  logic              tx_done;
  logic              frm_err;

  modport master (
    input  rx_rdy, rx_data, res_vld, res_digit, tx_done,
    output clr_rx_rdy, wr_en, wr_addr, wr_data,
    output img_rdy, trmt, tx_data, frm_err
  );

  modport slave (
    output rx_rdy, rx_data, res_vld, res_digit, tx_done,
    input  clr_rx_rdy, wr_en, wr_addr, wr_data,
    input  img_rdy, trmt, tx_data, frm_err
  );
endinterface

// File: rtl/uart_img_loader.sv
// Frame receiver (sync + NUM_PIX pixels) into image buffer, then ASCII result out.
// Ports: clk, rst_n (async low), bus (uart_img_loader_if.master). Macro UART_IMG_CHKSUM_EN adds checksum byte.
module uart_img_loader #(
  parameter int         NUM_PIX   = 784,
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_img_loader_if.master bus
);
  typedef enum logic [2:0] {
    SYNC,
    LOAD,
`ifdef UART_IMG_CHKSUM_EN
    CHK,
`endif
    WAIT_RES,
    TX,
    TX_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_PIX - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              img_pend_q;
  logic              img_rdy_q;
  logic              trmt_q;
  logic [7:0]        tx_data_q;
  logic              acc;
  logic [7:0]        tx_char_d;

  // Every offered byte is consumed at once, in every state.
  assign acc            = bus.rx_rdy & rst_n;
  assign bus.clr_rx_rdy = acc;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.img_rdy    = img_rdy_q;
  assign bus.trmt       = trmt_q;
  assign bus.tx_data    = tx_data_q;

  always_comb begin
    tx_char_d = 8'h3F;
    if (bus.res_digit <= 4'd9)
      tx_char_d = 8'h30 + {4'h0, bus.res_digit};
  end

`ifdef UART_IMG_CHKSUM_EN
  logic       frm_err_q;
  logic [7:0] sum_q;
  logic [7:0] sum_d;
  assign sum_d       = sum_q + bus.rx_data;
  assign bus.frm_err = frm_err_q;
`else
  assign bus.frm_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      img_pend_q <= 1'b0;
      img_rdy_q  <= 1'b0;
      trmt_q     <= 1'b0;
      tx_data_q  <= '0;
`ifdef UART_IMG_CHKSUM_EN
      frm_err_q  <= 1'b0;
      sum_q      <= '0;
`endif
    end else begin
      wr_en_q    <= 1'b0;
      trmt_q     <= 1'b0;
      // img_rdy trails the final write strobe by one cycle.
      img_rdy_q  <= img_pend_q;
      img_pend_q <= 1'b0;
      unique case (state_q)
        SYNC: begin
          if (acc && bus.rx_data == SYNC_BYTE) begin
            cnt_q   <= '0;
            state_q <= LOAD;
`ifdef UART_IMG_CHKSUM_EN
            frm_err_q <= 1'b0;
            sum_q     <= '0;
`endif
          end
        end
        LOAD: begin
          if (acc) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt_q;
            wr_data_q <= bus.rx_data;
`ifdef UART_IMG_CHKSUM_EN
            sum_q     <= sum_d;
`endif
            if (cnt_q == LAST) begin
`ifdef UART_IMG_CHKSUM_EN
              state_q <= CHK;
`else
              img_pend_q <= 1'b1;
              state_q    <= WAIT_RES;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_IMG_CHKSUM_EN
        CHK: begin
          if (acc) begin
            if (bus.rx_data == sum_q) begin
              img_rdy_q <= 1'b1;
              state_q   <= WAIT_RES;
            end else begin
              frm_err_q <= 1'b1;
              tx_data_q <= 8'h15;
              trmt_q    <= 1'b1;
              state_q   <= TX;
            end
          end
        end
`endif
        WAIT_RES: begin
          // Result cannot precede img_rdy, so ignore it while still pending.
          if (bus.res_vld && !img_pend_q) begin
            tx_data_q <= tx_char_d;
            trmt_q    <= 1'b1;
            state_q   <= TX;
          end
        end
        // trmt is high during TX; tx_done may still be stale here.
        TX:      state_q <= TX_WAIT;
        TX_WAIT: if (bus.tx_done) state_q <= SYNC;
        default: state_q <= SYNC;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_img_loader.sv
// Scoreboard bench for uart_img_loader: pixel writes, img_rdy, tx result bytes.
// Drives UART rx bytes, CNN result and a UART tx model through the interface.
module tb_uart_img_loader;
  localparam int NUM_PIX = 784;
  localparam int ADDR_W  = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_img_loader_if #(.ADDR_W(ADDR_W)) bus();

  uart_img_loader #(
    .NUM_PIX(NUM_PIX),
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hAA)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int errors = 0;
  int checks = 0;
  logic [17:0] wq[$];
  logic [7:0]  tq[$];
  logic [9:0]  exp_addr;
  int wr_cnt = 0, wr_exp = 0;
  int img_cnt = 0, img_exp = 0;
  int trmt_cnt = 0, tx_exp_n = 0;
  int tx_cnt;
  bit last_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // UART tx model: drops tx_done the cycle after trmt, raises it 20 later.
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.tx_done <= 1'b1;
      tx_cnt      <= 0;
    end else if (bus.trmt) begin
      bus.tx_done <= 1'b0;
      tx_cnt      <= 20;
    end else if (!bus.tx_done) begin
      if (tx_cnt == 0) bus.tx_done <= 1'b1;
      else tx_cnt <= tx_cnt - 1;
    end
  end

  always @(negedge clk) begin
    logic [17:0] e;
    if (bus.wr_en === 1'b1) begin
      wr_cnt++;
      if (wq.size() == 0) chk("wr_unexp", 1, 0);
      else begin
        e = wq.pop_front();
        chk("wr_addr", bus.wr_addr, e[17:8]);
        chk("wr_data", bus.wr_data, e[7:0]);
      end
    end
    if (bus.img_rdy === 1'b1) begin
      img_cnt++;
`ifndef UART_IMG_CHKSUM_EN
      chk("img_lat", last_wr, 1);
`endif
    end
    last_wr = (bus.wr_en === 1'b1) && (bus.wr_addr == NUM_PIX - 1);
    if (bus.trmt === 1'b1) begin
      trmt_cnt++;
      if (tq.size() == 0) chk("trmt_unexp", 1, 0);
      else chk("tx_data", bus.tx_data, tq.pop_front());
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit pix);
    @(negedge clk);
    if (pix) begin
      wq.push_back({exp_addr, b});
      exp_addr++;
      wr_exp++;
    end
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    #1 chk("clr", bus.clr_rx_rdy, 1);
    @(negedge clk);
    bus.rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input bit bad, input bit poke_res);
    logic [7:0] sum = 8'h00;
    exp_addr = '0;
    send_byte(8'hAA, 1'b0);
`ifdef UART_IMG_CHKSUM_EN
    chk("frm_clr", bus.frm_err, 0);
`endif
    for (int i = 0; i < NUM_PIX; i++) begin
      logic [7:0] b = 8'(i);
      sum += b;
      bus.res_vld = poke_res && (i == 50);
      send_byte(b, 1'b1);
      bus.res_vld = 1'b0;
    end
`ifdef UART_IMG_CHKSUM_EN
    if (bad) begin
      tq.push_back(8'h15);
      tx_exp_n++;
      send_byte(sum + 8'd1, 1'b0);
    end else begin
      send_byte(sum, 1'b0);
    end
`endif
    if (!bad) img_exp++;
    repeat (3) @(negedge clk);
    chk("img_cnt", img_cnt, img_exp);
    chk("wq_empty", wq.size(), 0);
  endtask

  task automatic tx_xact(input bit use_res, input logic [3:0] d,
                         input logic [7:0] exp, input int ndrop);
    if (use_res) begin
      @(negedge clk);
      tq.push_back(exp);
      tx_exp_n++;
      bus.res_vld   = 1'b1;
      bus.res_digit = d;
      @(negedge clk);
      bus.res_vld = 1'b0;
    end
    for (int i = 0; i < 50 && trmt_cnt < tx_exp_n; i++) @(negedge clk);
    chk("trmt_seen", trmt_cnt, tx_exp_n);
    for (int i = 0; i < ndrop; i++) send_byte(8'hAA - 8'(i), 1'b0);
    for (int i = 0; i < 60 && bus.tx_done !== 1'b1; i++) @(negedge clk);
    chk("tx_done_to", bus.tx_done, 1);
    chk("tx_hold", bus.tx_data, exp);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.rx_rdy    = 1'b1;
    bus.rx_data   = 8'hAA;
    bus.res_vld   = 1'b0;
    bus.res_digit = 4'd0;
    exp_addr      = '0;
    repeat (4) @(negedge clk);
    chk("rst_outs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.img_rdy,
                     bus.trmt, bus.tx_data, bus.frm_err}, 0);
    chk("rst_clr", bus.clr_rx_rdy, 0);
    rst_n       = 1'b1;
    bus.rx_data = 8'h55;
    #1 chk("clr_55", bus.clr_rx_rdy, 1);
    @(negedge clk);
    bus.rx_rdy = 1'b0;

    send_frame(1'b0, 1'b0);
    tx_xact(1'b1, 4'd7, 8'h37, 0);

    send_frame(1'b0, 1'b1);
    tx_xact(1'b1, 4'd12, 8'h3F, 3);

`ifdef UART_IMG_CHKSUM_EN
    send_frame(1'b1, 1'b0);
    tx_xact(1'b0, 4'd0, 8'h15, 0);
    chk("frm_err", bus.frm_err, 1);
    send_frame(1'b0, 1'b0);
    tx_xact(1'b1, 4'd3, 8'h33, 0);
`endif

    exp_addr = '0;
    send_byte(8'hAA, 1'b0);
    for (int i = 0; i < 100; i++) send_byte(8'(i), 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", {bus.wr_en, bus.wr_addr, bus.wr_data, bus.img_rdy,
                         bus.trmt, bus.tx_data, bus.frm_err}, 0);
    chk("mid_rst_wq", wq.size(), 0);
    rst_n = 1'b1;
    send_frame(1'b0, 1'b0);
    tx_xact(1'b1, 4'd0, 8'h30, 0);

    repeat (5) @(negedge clk);
    chk("wr_total", wr_cnt, wr_exp);
    chk("img_total", img_cnt, img_exp);
    chk("trmt_total", trmt_cnt, tx_exp_n);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
